// File: rtl/eth_pkg.sv
// eth_pkg: shared states, wire constants and FCS byte helper for the GMII transmit path
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int          PREAMBLE_LEN  = 7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

    function automatic logic [7:0] fcs_byte(input logic [31:0] c, input logic [1:0] idx);
        logic [7:0] s;
        s = 8'(c >> {2'd3 - idx, 3'd0});
        return ~{s[0], s[1], s[2], s[3], s[4], s[5], s[6], s[7]};
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: byte-wide MSB-first CRC-32 (0x04C11DB7), data bits consumed LSB first; clr beats en
module crc32_d8
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        crc_clr,
    input  logic        crc_en,
    input  logic [7:0]  data,
    output logic [31:0] crc_data
);

    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic [31:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        for (int i = 0; i < 8; i++)
            crc_d = {crc_d[30:0], 1'b0} ^ ((crc_d[31] ^ data[i]) ? POLY : 32'h0);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) crc_q <= CRC_INIT;
        else if (crc_clr) crc_q <= CRC_INIT;
        else if (crc_en) crc_q <= crc_d;

    assign crc_data = crc_q;

endmodule

// File: rtl/eth_mac_tx.sv
// eth_mac_tx: GMII MAC transmitter - preamble/SFD, frame bytes, zero pad, FCS, IFG; underrun aborts
module eth_mac_tx
    import eth_pkg::*;
#(
    parameter int MIN_FRAME  = 60,
    parameter int IFG_CYCLES = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic [7:0] gmii_txd,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    localparam logic [16:0] MIN_P1   = 17'(MIN_FRAME + 1);
    localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
    localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, ph_q, ph_d, cnt_inc;
    logic        last_q, last_d;
    logic        en_d, er_d, done_d, ur_d, crc_en, accept, starve, need_pad;
    logic [7:0]  txd_d;
    logic [31:0] crc_data;

    // state names what is on the wire this cycle; outputs register what the next cycle shows
    assign s_ready  = state_q == ST_SFD || (state_q == ST_DATA && !last_q);
    assign busy     = state_q != ST_IDLE;
    assign accept   = s_ready && s_valid;
    assign starve   = s_ready && !s_valid;
    assign need_pad = ({1'b0, cnt_q} + 17'd1) < MIN_P1;
    assign cnt_inc  = &cnt_q ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        last_d  = last_q;
        en_d    = 1'b1;
        er_d    = 1'b0;
        done_d  = 1'b0;
        ur_d    = 1'b0;
        txd_d   = 8'h00;
        crc_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                en_d   = s_valid;
                cnt_d  = '0;
                ph_d   = '0;
                last_d = 1'b0;
                txd_d  = s_valid ? PREAMBLE_BYTE : 8'h00;
                if (s_valid) state_d = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                ph_d  = ph_q + 16'd1;
                txd_d = ph_q == PRE_LAST ? SFD_BYTE : PREAMBLE_BYTE;
                if (ph_q == PRE_LAST) state_d = ST_SFD;
            end
            ST_SFD, ST_DATA, ST_PAD: begin
                if (starve) begin
                    state_d = ST_IFG;
                    er_d    = 1'b1;
                    ur_d    = 1'b1;
                    ph_d    = '0;
                end else if (accept) begin
                    state_d = ST_DATA;
                    txd_d   = s_data;
                    crc_en  = 1'b1;
                    cnt_d   = cnt_inc;
                    last_d  = s_last;
                end else begin
                    // last byte is on the wire: queue a pad byte or the first FCS byte
                    ph_d    = '0;
                    state_d = need_pad ? ST_PAD : ST_FCS;
                    crc_en  = need_pad;
                    cnt_d   = need_pad ? cnt_inc : cnt_q;
                    txd_d   = need_pad ? 8'h00 : fcs_byte(crc_data, 2'd0);
                end
            end
            ST_FCS: begin
                ph_d   = ph_q == 16'd3 ? '0 : ph_q + 16'd1;
                en_d   = ph_q != 16'd3;
                done_d = ph_q == 16'd3;
                txd_d  = ph_q == 16'd3 ? 8'h00 : fcs_byte(crc_data, ph_q[1:0] + 2'd1);
                if (ph_q == 16'd3) state_d = ST_IFG;
            end
            ST_IFG: begin
                // the error cycle of an aborted frame does not count toward the gap
                en_d = 1'b0;
                ph_d = gmii_tx_er ? ph_q : ph_q + 16'd1;
                if (!gmii_tx_er && ph_q == IFG_LAST) state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ph_q       <= '0;
            last_q     <= 1'b0;
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            gmii_txd   <= 8'h00;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ph_q       <= ph_d;
            last_q     <= last_d;
            gmii_tx_en <= en_d;
            gmii_tx_er <= er_d;
            gmii_txd   <= txd_d;
            frame_done <= done_d;
            underrun   <= ur_d;
        end
    end

    crc32_d8 u_crc (
        .clk      (clk),
        .rst_n    (rst_n),
        .crc_clr  (state_q == ST_IDLE),
        .crc_en   (crc_en),
        .data     (txd_d),
        .crc_data (crc_data)
    );

endmodule

// File: tb/tb_eth_mac_tx.sv
// tb_eth_mac_tx: directed checks of two MAC instances (padding on / off) against a software wire model
module tb_eth_mac_tx;

    logic       clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0, s_last = 1'b0;
    logic       va, vb, rdy_a, rdy_b, en_a, en_b, er_a, er_b, busy_a, busy_b, done_a, done_b, ur_a, ur_b;
    logic [7:0] txd_a, txd_b;
    logic       m_en, m_er, m_rdy, m_busy, m_done, m_ur;
    logic [7:0] m_txd;

    logic [7:0] frm [0:127];
    logic [7:0] cap[$], exp_q[$];
    int n_cmp = 0, n_bad = 0;
    int cyc = 0, gap = 0, last_gap = 0, en_rise = 0, start_cyc = 0;
    int done_cnt = 0, ur_cnt = 0, er_cnt = 0, rdy_cnt = 0;
    logic prev_en = 1'b0;

    always #4 clk = ~clk;

    assign va     = s_valid & ~sel;
    assign vb     = s_valid & sel;
    assign m_en   = sel ? en_b : en_a;
    assign m_er   = sel ? er_b : er_a;
    assign m_rdy  = sel ? rdy_b : rdy_a;
    assign m_busy = sel ? busy_b : busy_a;
    assign m_done = sel ? done_b : done_a;
    assign m_ur   = sel ? ur_b : ur_a;
    assign m_txd  = sel ? txd_b : txd_a;

    eth_mac_tx dut_a (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(va), .s_last(s_last), .s_ready(rdy_a),
        .gmii_tx_en(en_a), .gmii_tx_er(er_a), .gmii_txd(txd_a), .busy(busy_a),
        .frame_done(done_a), .underrun(ur_a)
    );

    eth_mac_tx #(.MIN_FRAME(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(vb), .s_last(s_last), .s_ready(rdy_b),
        .gmii_tx_en(en_b), .gmii_tx_er(er_b), .gmii_txd(txd_b), .busy(busy_b),
        .frame_done(done_b), .underrun(ur_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_en) begin
            cap.push_back(m_txd);
            if (!prev_en) begin
                en_rise  = cyc;
                last_gap = gap;
            end
            gap = 0;
        end else gap++;
        prev_en  = m_en;
        done_cnt += int'(m_done);
        ur_cnt   += int'(m_ur);
        er_cnt   += int'(m_er);
        rdy_cnt  += int'(m_rdy);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // expected wire bytes: preamble, SFD, n data bytes, zero pad to minf, reflected CRC-32 LSB first
    task automatic build_exp(input int n, input int minf, input bit with_fcs);
        logic [31:0] c;
        logic [7:0]  b;
        int tot;
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        tot = n < minf ? minf : n;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < tot; i++) begin
            b = i < n ? frm[i] : 8'h00;
            exp_q.push_back(b);
            c ^= {24'h0, b};
            for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
        end
        c = ~c;
        if (with_fcs) for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
    endtask

    function automatic int first_diff();
        for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
            if (cap[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic send(input int n, input int drop, input bit hold);
        int i, guard;
        i = 0;
        guard = 0;
        @(negedge clk);
        while (i < n && guard < 400) begin
            if (i == drop) s_valid = 1'b0;
            else begin
                s_valid = 1'b1;
                s_data  = frm[i];
                s_last  = i == n - 1;
            end
            if (i == 0 && guard == 0) start_cyc = cyc;
            if (m_rdy && i == drop) begin
                @(negedge clk);
                break;
            end
            if (m_rdy) i++;
            @(negedge clk);
            guard++;
        end
        check("send timeout", guard < 400, 1);
        s_valid = hold;
        s_last  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int g;
        g = 0;
        while (m_busy && g < 400) begin
            @(negedge clk);
            g++;
        end
        check(tag, m_busy, 0);
    endtask

    task automatic wait_done(input int target, input string tag);
        int g;
        g = 0;
        while (done_cnt < target && g < 400) begin
            @(negedge clk);
            g++;
        end
        check(tag, done_cnt >= target, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0, r0, u0;
        repeat (3) @(negedge clk);
        check("rst tx_en", m_en, 0);
        check("rst tx_er", m_er, 0);
        check("rst txd", m_txd, 8'h00);
        check("rst s_ready", m_rdy, 0);
        check("rst busy", m_busy, 0);
        check("rst frame_done", m_done, 0);
        check("rst underrun", m_ur, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // "123456789" without padding
        sel = 1'b1;
        cap.delete();
        for (int i = 0; i < 9; i++) frm[i] = 8'h31 + 8'(i);
        d0 = done_cnt;
        r0 = rdy_cnt;
        send(9, -1, 1'b0);
        wait_idle("t1 idle");
        build_exp(9, 0, 1'b1);
        check("t1 latency", en_rise - start_cyc, 1);
        check("t1 len", cap.size(), 21);
        check("t1 stream", first_diff(), -1);
        check("t1 fcs0", cap[17], 8'h26);
        check("t1 fcs1", cap[18], 8'h39);
        check("t1 fcs2", cap[19], 8'hF4);
        check("t1 fcs3", cap[20], 8'hCB);
        check("t1 done", done_cnt - d0, 1);
        check("t1 ready cycles", rdy_cnt - r0, 9);
        repeat (2) @(negedge clk);

        // single byte padded to 60
        sel = 1'b0;
        cap.delete();
        frm[0] = 8'hAB;
        d0 = done_cnt;
        r0 = rdy_cnt;
        send(1, -1, 1'b0);
        wait_idle("t2 idle");
        build_exp(1, 60, 1'b1);
        check("t2 len", cap.size(), 72);
        check("t2 stream", first_diff(), -1);
        check("t2 pad byte", cap[40], 8'h00);
        check("t2 done", done_cnt - d0, 1);
        check("t2 ready cycles", rdy_cnt - r0, 1);
        repeat (2) @(negedge clk);

        // 64-byte frame, s_valid held through IFG, then 30-byte frame
        cap.delete();
        for (int i = 0; i < 64; i++) frm[i] = 8'(i * 3 + 1);
        d0 = done_cnt;
        send(64, -1, 1'b1);
        wait_done(d0 + 1, "t3 done1 wait");
        build_exp(64, 60, 1'b1);
        check("t3 len1", cap.size(), 76);
        check("t3 stream1", first_diff(), -1);
        cap.delete();
        for (int i = 0; i < 30; i++) frm[i] = 8'hC0 ^ 8'(i);
        send(30, -1, 1'b0);
        wait_idle("t3 idle");
        build_exp(30, 60, 1'b1);
        check("t3 gap", last_gap, 13);
        check("t3 len2", cap.size(), 72);
        check("t3 stream2", first_diff(), -1);
        check("t3 done", done_cnt - d0, 2);
        repeat (2) @(negedge clk);

        // underrun at byte 10 of a 20-byte frame, then a clean frame
        cap.delete();
        for (int i = 0; i < 20; i++) frm[i] = 8'h10 + 8'(i);
        d0 = done_cnt;
        u0 = ur_cnt;
        r0 = er_cnt;
        send(20, 9, 1'b0);
        wait_idle("t4 idle");
        build_exp(9, 0, 1'b0);
        exp_q.push_back(8'h00);
        check("t4 len", cap.size(), 18);
        check("t4 stream", first_diff(), -1);
        check("t4 underrun", ur_cnt - u0, 1);
        check("t4 tx_er cycles", er_cnt - r0, 1);
        check("t4 no done", done_cnt - d0, 0);
        cap.delete();
        for (int i = 0; i < 20; i++) frm[i] = 8'hA0 + 8'(i);
        send(20, -1, 1'b0);
        wait_idle("t4b idle");
        build_exp(20, 60, 1'b1);
        check("t4b len", cap.size(), 72);
        check("t4b stream", first_diff(), -1);
        check("t4b done", done_cnt - d0, 1);
        repeat (2) @(negedge clk);

        // asynchronous reset during PAD, then a 60-byte frame
        frm[0] = 8'h5A;
        send(1, -1, 1'b0);
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t5 rst tx_en", m_en, 0);
        check("t5 rst txd", m_txd, 8'h00);
        check("t5 rst busy", m_busy, 0);
        check("t5 rst tx_er", m_er, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cap.delete();
        d0 = done_cnt;
        for (int i = 0; i < 60; i++) frm[i] = 8'(i * 7);
        send(60, -1, 1'b0);
        wait_idle("t5 idle");
        build_exp(60, 60, 1'b1);
        check("t5 len", cap.size(), 72);
        check("t5 stream", first_diff(), -1);
        check("t5 done", done_cnt - d0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
